hd44780_writer: RTL and testbench

Timed write engine for the HD44780 character LCD, sitting downstream of the CPU I/O port that today bit-bangs `hd_dc`, `hd_e` and `hd_data`. The CPU pushes {dc, byte} words into a small FIFO. The block replays each word to the panel with correct address-setup, E-pulse and execution-wait timing, so firmware no longer spins in delay loops. Clear (0x01) and home (0x02) commands automatically get the long execution wait.

---
 rtl/hd44780_writer.sv | 99 +++++++++
 tb/tb_hd44780_writer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hd44780_writer.sv
// hd44780_writer: FIFO-fed timed write engine driving HD44780 RS/E/DB outputs
module hd44780_writer #(
  parameter int SETUP_CYCLES = 2,
  parameter int E_CYCLES     = 16,
  parameter int EXEC_CYCLES  = 1200,
  parameter int LONG_CYCLES  = 45000,
  parameter int FIFO_BITS    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic       wr_dc,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       hd_dc,
  output logic       hd_e,
  output logic [7:0] hd_data
);
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, WAIT} state_t;
  localparam logic [15:0] C_SETUP = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] C_E     = 16'(E_CYCLES - 1);
  localparam logic [15:0] C_EXEC  = 16'(EXEC_CYCLES - 1);
  localparam logic [15:0] C_LONG  = 16'(LONG_CYCLES - 1);
  state_t r_state, w_state_n;
  logic [15:0] r_cnt, w_cnt_n;
  logic [8:0] r_mem [2**FIFO_BITS];
  logic [FIFO_BITS:0] r_wp, r_rp, w_wp_n, w_rp_n;
  logic w_empty, w_full, w_push, w_pop, w_long, w_zero, w_e_n, w_dc_n;
  logic [7:0] w_data_n;
  assign w_empty  = r_wp == r_rp;
  assign w_full   = (r_wp[FIFO_BITS] != r_rp[FIFO_BITS]) && (r_wp[FIFO_BITS-1:0] == r_rp[FIFO_BITS-1:0]);
  assign w_push   = wr && !w_full;
  assign w_pop    = (r_state == IDLE) && !w_empty;
  assign w_wp_n   = r_wp + {{FIFO_BITS{1'b0}}, w_push};
  assign w_rp_n   = r_rp + {{FIFO_BITS{1'b0}}, w_pop};
  assign w_long   = !hd_dc && (hd_data == 8'h01 || hd_data == 8'h02);
  assign w_zero   = r_cnt == 16'd0;
  assign full     = w_full;
  // Storage needs no reset: flushing the pointers empties the FIFO
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[FIFO_BITS-1:0]] <= {wr_dc, wr_data};
  end
  // Next-state: the bus only changes on the pop, E toggles at counter expiry
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = (r_state != IDLE && !w_zero) ? r_cnt - 16'd1 : r_cnt;
    w_e_n     = hd_e;
    w_dc_n    = hd_dc;
    w_data_n  = hd_data;
    unique case (r_state)
      IDLE: begin
        w_e_n = 1'b0;
        if (w_pop) begin
          w_state_n          = SETUP;
          w_cnt_n            = C_SETUP;
          {w_dc_n, w_data_n} = r_mem[r_rp[FIFO_BITS-1:0]];
        end
      end
      SETUP: if (w_zero) begin
        w_state_n = PULSE;
        w_cnt_n   = C_E;
        w_e_n     = 1'b1;
      end
      PULSE: if (w_zero) begin
        w_state_n = WAIT;
        w_cnt_n   = w_long ? C_LONG : C_EXEC;
        w_e_n     = 1'b0;
      end
      WAIT: if (w_zero) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end
  // State, pointers and registered outputs; reset drops E immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 16'd0;
      r_wp     <= '0;
      r_rp     <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      hd_dc    <= 1'b0;
      hd_e     <= 1'b0;
      hd_data  <= 8'h00;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_wp     <= w_wp_n;
      r_rp     <= w_rp_n;
      overflow <= overflow || (wr && w_full);
      busy     <= (w_wp_n != w_rp_n) || (w_state_n != IDLE);
      hd_dc    <= w_dc_n;
      hd_e     <= w_e_n;
      hd_data  <= w_data_n;
    end
  end
endmodule

// File: tb/tb_hd44780_writer.sv
// tb_hd44780_writer: directed timing checks of the HD44780 write engine
module tb_hd44780_writer;
  logic clk = 1'b0, reset = 1'b1, wr = 1'b0, wr_dc = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, busy, overflow, hd_dc, hd_e;
  logic [7:0] hd_data;
  int total = 0, bad = 0, e = 0;
  hd44780_writer #(.SETUP_CYCLES(2), .E_CYCLES(16), .EXEC_CYCLES(1200), .LONG_CYCLES(3000), .FIFO_BITS(2)) dut (
    .clk(clk), .reset(reset), .wr(wr), .wr_dc(wr_dc), .wr_data(wr_data),
    .full(full), .busy(busy), .overflow(overflow),
    .hd_dc(hd_dc), .hd_e(hd_e), .hd_data(hd_data)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask
  task automatic tick_to(input int n);
    while (e < n) tick();
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at edge %0d: got %0h want %0h", tag, e, obs, exp);
    end
  endtask
  task automatic push(input logic dc, input logic [7:0] d);
    wr = 1'b1;
    wr_dc = dc;
    wr_data = d;
    tick();
    wr = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e = -1;
  endtask
  initial begin
    do_reset();
    chk("rst_e", 32'(hd_e), 0);
    chk("rst_dc", 32'(hd_dc), 0);
    chk("rst_data", 32'(hd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    push(1'b0, 8'h38);
    chk("t1_busy0", 32'(busy), 1);
    chk("t1_data0", 32'(hd_data), 8'h00);
    tick_to(1);
    chk("t1_data1", 32'(hd_data), 8'h38);
    chk("t1_dc1", 32'(hd_dc), 0);
    chk("t1_e1", 32'(hd_e), 0);
    tick_to(2);
    chk("t1_e2", 32'(hd_e), 0);
    tick_to(3);
    chk("t1_e3", 32'(hd_e), 1);
    tick_to(18);
    chk("t1_e18", 32'(hd_e), 1);
    tick_to(19);
    chk("t1_e19", 32'(hd_e), 0);
    chk("t1_hold", 32'(hd_data), 8'h38);
    tick_to(1218);
    chk("t1_busy1218", 32'(busy), 1);
    tick_to(1219);
    chk("t1_busy1219", 32'(busy), 0);
    do_reset();
    push(1'b0, 8'h01);
    push(1'b1, 8'h41);
    tick_to(1);
    chk("t2_clr", 32'(hd_data), 8'h01);
    tick_to(3019);
    chk("t2_long_hold", 32'(hd_data), 8'h01);
    tick_to(3020);
    chk("t2_next", 32'(hd_data), 8'h41);
    chk("t2_dc", 32'(hd_dc), 1);
    tick_to(4237);
    chk("t2_busy", 32'(busy), 1);
    tick_to(4238);
    chk("t2_idle", 32'(busy), 0);
    do_reset();
    for (int i = 0; i < 5; i++) push(1'b1, 8'(8'h61 + i));
    chk("t3_full", 32'(full), 1);
    chk("t3_noovf", 32'(overflow), 0);
    push(1'b1, 8'h66);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_full5", 32'(full), 1);
    for (int i = 0; i < 5; i++) begin
      tick_to(1 + 1219 * i);
      chk("t3_pop", 32'(hd_data), 32'(8'h61 + i));
      if (i == 1) chk("t3_unfull", 32'(full), 0);
    end
    tick_to(6095);
    chk("t3_last", 32'(hd_data), 8'h65);
    chk("t3_drained", 32'(busy), 0);
    chk("t3_sticky", 32'(overflow), 1);
    do_reset();
    chk("t4_ovf_clr", 32'(overflow), 0);
    push(1'b1, 8'h41);
    tick_to(1218);
    wr = 1'b1;
    wr_dc = 1'b1;
    wr_data = 8'h42;
    tick();
    wr = 1'b0;
    chk("t4_busy", 32'(busy), 1);
    chk("t4_nopop", 32'(hd_data), 8'h41);
    tick_to(1220);
    chk("t4_pop", 32'(hd_data), 8'h42);
    tick_to(1222);
    chk("t4_e", 32'(hd_e), 1);
    tick_to(2438);
    chk("t4_idle", 32'(busy), 0);
    chk("t4_data", 32'(hd_data), 8'h42);
    do_reset();
    for (int i = 0; i < 6; i++) push(1'b0, 8'(8'h30 + i));
    chk("t5_e_hi", 32'(hd_e), 1);
    chk("t5_ovf", 32'(overflow), 1);
    do_reset();
    chk("t5_e_lo", 32'(hd_e), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_full", 32'(full), 0);
    chk("t5_ovf_clr", 32'(overflow), 0);
    chk("t5_data", 32'(hd_data), 0);
    tick_to(5);
    chk("t5_flushed", 32'(busy), 0);
    chk("t5_quiet", 32'(hd_data), 0);
    e = -1;
    push(1'b0, 8'h0C);
    tick_to(1);
    chk("t5_pop", 32'(hd_data), 8'h0C);
    tick_to(3);
    chk("t5_rise", 32'(hd_e), 1);
    tick_to(19);
    chk("t5_fall", 32'(hd_e), 0);
    tick_to(1219);
    chk("t5_idle", 32'(busy), 0);
    do_reset();
    push(1'b0, 8'h02);
    push(1'b1, 8'h01);
    tick_to(3019);
    chk("t6_home", 32'(hd_data), 8'h02);
    tick_to(3020);
    chk("t6_data", 32'(hd_data), 8'h01);
    chk("t6_dc", 32'(hd_dc), 1);
    tick_to(4237);
    chk("t6_busy", 32'(busy), 1);
    tick_to(4238);
    chk("t6_short", 32'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
